// File: rtl/gpio_irq_pkg.sv
// gpio_irq_pkg: shared constants for the banked GPIO block with edge interrupts.
// Register select values occupy Addr[5:3]; each bank covers 16 pins.
package gpio_irq_pkg;

   localparam int BANK_BITS = 16;
   localparam int MAX_WIDTH = 128;

   typedef enum logic [2:0] {
      REG_OUT     = 3'd0,
      REG_DIR     = 3'd1,
      REG_PIN     = 3'd2,
      REG_RISE_EN = 3'd3,
      REG_FALL_EN = 3'd4,
      REG_STAT    = 3'd5,
      REG_OUT_SET = 3'd6,
      REG_OUT_CLR = 3'd7
   } reg_sel_e;

endpackage

// File: rtl/gpio_irq_if.sv
// gpio_irq_if: secondary cartridge register bus as seen by the GPIO block.
// The master (bus decoder / testbench) drives address, data and qualifiers;
// the slave (gpio_irq) returns read data combinationally.
interface gpio_irq_if;

   logic [5:0]  Addr;
   logic [15:0] DataWr;
   logic [15:0] DataRd;
   logic        En;
   logic        Rd;
   logic        Wr;

   modport master (
      output Addr,
      output DataWr,
      output En,
      output Rd,
      output Wr,
      input  DataRd
   );

   modport slave (
      input  Addr,
      input  DataWr,
      input  En,
      input  Rd,
      input  Wr,
      output DataRd
   );

endinterface

// File: rtl/gpio_irq_bit.sv
// gpio_irq_bit: one pin's input path -- two-flop synchroniser, filtered level,
// edge detection and the sticky write-1-to-clear status bit.
// Optional macro GPIO_DEBOUNCE_EN adds a 2-bit tick-sampled history so that
// the filtered level only moves after three consecutive agreeing ticks.
module gpio_irq_bit (
   input  logic clk,
   input  logic rst,
   input  logic pad,
`ifdef GPIO_DEBOUNCE_EN
   input  logic tick,
`endif
   input  logic rise_en,
   input  logic fall_en,
   input  logic clr,
   output logic filt,
   output logic stat
);

   logic sync1_q, sync1_d;
   logic sync2_q, sync2_d;
   logic filt_q, filt_d;
   logic prev_q, prev_d;
   logic stat_q, stat_d;
   logic rise, fall;

`ifdef GPIO_DEBOUNCE_EN
   logic [1:0] hist_q, hist_d;

   // Filtered level follows sync2 only when the two previous tick samples agree with it
   always_comb begin
      hist_d = hist_q;
      filt_d = filt_q;
      if (tick) begin
         hist_d = {hist_q[0], sync2_q};
         if ((sync2_q == hist_q[0]) && (sync2_q == hist_q[1])) begin
            filt_d = sync2_q;
         end
      end
   end

   // Tick-sampled history register
   always_ff @(posedge clk) begin
      if (rst) begin
         hist_q <= '0;
      end else begin
         hist_q <= hist_d;
      end
   end
`else
   // Without debounce the filtered level is simply sync2 one cycle later
   always_comb begin
      filt_d = sync2_q;
   end
`endif

   // Synchroniser chain, edge detect and sticky status next-state
   always_comb begin
      sync1_d = pad;
      sync2_d = sync1_q;
      prev_d  = filt_q;
      rise    = filt_q & ~prev_q;
      fall    = ~filt_q & prev_q;
      stat_d  = (stat_q & ~clr) | (rise & rise_en) | (fall & fall_en);
   end

   // Pin state registers
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         filt_q  <= 1'b0;
         prev_q  <= 1'b0;
         stat_q  <= 1'b0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         filt_q  <= filt_d;
         prev_q  <= prev_d;
         stat_q  <= stat_d;
      end
   end

   assign filt = filt_q;
   assign stat = stat_q;

endmodule

// File: rtl/gpio_irq.sv
// gpio_irq: banked GPIO with per-pin direction, atomic output set/clear,
// synchronised inputs and rising/falling edge capture into a sticky status
// register with a registered interrupt output.
// Optional macro GPIO_DEBOUNCE_EN adds a DEB_DIV-cycle sample prescaler and
// per-pin debounce history; the default build has neither.
module gpio_irq
   import gpio_irq_pkg::*;
#(
   parameter int WIDTH   = 64,
   parameter int DEB_DIV = 1024
) (
   input  logic            Clk,
   input  logic            Reset,
   gpio_irq_if.slave       bus,
   inout  wire [WIDTH-1:0] P,
   output logic            Irq
);

   localparam int NBANK = WIDTH / BANK_BITS;

   if (((WIDTH % BANK_BITS) != 0) || (WIDTH < BANK_BITS) || (WIDTH > MAX_WIDTH) || (DEB_DIV < 2)) begin : g_bad_param
      $error("gpio_irq: unsupported WIDTH or DEB_DIV");
   end

   logic [WIDTH-1:0] out_q, out_d;
   logic [WIDTH-1:0] dir_q, dir_d;
   logic [WIDTH-1:0] rise_en_q, rise_en_d;
   logic [WIDTH-1:0] fall_en_q, fall_en_d;
   logic [WIDTH-1:0] stat_clr;
   logic [WIDTH-1:0] stat;
   logic [WIDTH-1:0] filt;
   logic             irq_q, irq_d;
   logic             wr_hit, rd_hit;
   logic [2:0]       bank;
   reg_sel_e         sel;
   logic [15:0]      rd_data;

   assign wr_hit = bus.En & bus.Wr;
   assign rd_hit = bus.En & bus.Rd;
   assign bank   = bus.Addr[2:0];
   assign sel    = reg_sel_e'(bus.Addr[5:3]);

`ifdef GPIO_DEBOUNCE_EN
   localparam int CNT_W = $clog2(DEB_DIV);

   logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;
   logic             deb_tick;

   // Prescaler wraps at DEB_DIV-1 and ticks on that count
   always_comb begin
      deb_tick  = (deb_cnt_q == CNT_W'(DEB_DIV - 1));
      deb_cnt_d = deb_tick ? '0 : (deb_cnt_q + CNT_W'(1));
   end

   // Prescaler counter register
   always_ff @(posedge Clk) begin
      if (Reset) begin
         deb_cnt_q <= '0;
      end else begin
         deb_cnt_q <= deb_cnt_d;
      end
   end
`endif

   // Bank write decode: plain writes, atomic set/clear of OUT, and STAT clear pulses
   always_comb begin
      out_d     = out_q;
      dir_d     = dir_q;
      rise_en_d = rise_en_q;
      fall_en_d = fall_en_q;
      stat_clr  = '0;
      for (int b = 0; b < NBANK; b++) begin
         if (wr_hit && (bank == 3'(b))) begin
            case (sel)
               REG_OUT:     out_d[b*BANK_BITS +: BANK_BITS]     = bus.DataWr;
               REG_DIR:     dir_d[b*BANK_BITS +: BANK_BITS]     = bus.DataWr;
               REG_RISE_EN: rise_en_d[b*BANK_BITS +: BANK_BITS] = bus.DataWr;
               REG_FALL_EN: fall_en_d[b*BANK_BITS +: BANK_BITS] = bus.DataWr;
               REG_STAT:    stat_clr[b*BANK_BITS +: BANK_BITS]  = bus.DataWr;
               REG_OUT_SET: out_d[b*BANK_BITS +: BANK_BITS]     = out_q[b*BANK_BITS +: BANK_BITS] | bus.DataWr;
               REG_OUT_CLR: out_d[b*BANK_BITS +: BANK_BITS]     = out_q[b*BANK_BITS +: BANK_BITS] & ~bus.DataWr;
               default:     ;
            endcase
         end
      end
   end

   // Combinational read mux; unmapped banks and the set/clear strobes read 0
   always_comb begin
      rd_data = '0;
      for (int b = 0; b < NBANK; b++) begin
         if (rd_hit && (bank == 3'(b))) begin
            case (sel)
               REG_OUT:     rd_data = out_q[b*BANK_BITS +: BANK_BITS];
               REG_DIR:     rd_data = dir_q[b*BANK_BITS +: BANK_BITS];
               REG_PIN:     rd_data = filt[b*BANK_BITS +: BANK_BITS];
               REG_RISE_EN: rd_data = rise_en_q[b*BANK_BITS +: BANK_BITS];
               REG_FALL_EN: rd_data = fall_en_q[b*BANK_BITS +: BANK_BITS];
               REG_STAT:    rd_data = stat[b*BANK_BITS +: BANK_BITS];
               default:     rd_data = '0;
            endcase
         end
      end
   end

   assign bus.DataRd = rd_data;

   // Interrupt is the OR of all status bits, registered
   always_comb begin
      irq_d = |stat;
   end

   // Control registers and interrupt flop; reset wins over a same-cycle write
   always_ff @(posedge Clk) begin
      if (Reset) begin
         out_q     <= '0;
         dir_q     <= '0;
         rise_en_q <= '0;
         fall_en_q <= '0;
         irq_q     <= 1'b0;
      end else begin
         out_q     <= out_d;
         dir_q     <= dir_d;
         rise_en_q <= rise_en_d;
         fall_en_q <= fall_en_d;
         irq_q     <= irq_d;
      end
   end

   assign Irq = irq_q;

   for (genvar i = 0; i < WIDTH; i++) begin : g_pin
      assign P[i] = dir_q[i] ? out_q[i] : 1'bz;

      gpio_irq_bit u_bit (
         .clk     (Clk),
         .rst     (Reset),
         .pad     (P[i]),
`ifdef GPIO_DEBOUNCE_EN
         .tick    (deb_tick),
`endif
         .rise_en (rise_en_q[i]),
         .fall_en (fall_en_q[i]),
         .clr     (stat_clr[i]),
         .filt    (filt[i]),
         .stat    (stat[i])
      );
   end

endmodule

// File: doc/gpio_irq.md
Name: gpio_irq

Overview:
Parametrised successor to the fixed 64-pin GPIO. Sits on the secondary cartridge register bus behind Primary, alongside existing peripherals. Adds:
- per-pin direction
- atomic set/clear of outputs
- two-flop input synchronisers
- per-pin rising/falling edge capture into sticky write-1-to-clear status, with a registered interrupt output.

Parameters:
WIDTH, 64, number of pins; multiple of 16, range 16..128; NBANK = WIDTH/16 (localparam)
DEB_DIV, 1024, debounce sample-tick period in Clk cycles (used only with GPIO_DEBOUNCE_EN); >=2

Ports:
Clk  input  1  system clock
Reset  input  1  synchronous, active-high reset
Addr  input  6  Addr[5:3] register select, Addr[2:0] bank (16 pins/bank)
DataWr  input  16  write data
DataRd  output  16  read data; 0 when !En or !Rd
En  input  1  block select, decoded by top level
Rd  input  1  read qualifier, level
Wr  input  1  write strobe, one Clk cycle per access
P  inout  WIDTH  pins
Irq  output  1  interrupt, active-high, registered

Behaviour:
- Access: a write occurs on a Clk edge with En&Wr. Bank >= NBANK: writes ignored, reads return 0.
- Reads are combinational from Addr/state.
- Register select:
  - 0 OUT: r/w
  - 1 DIR: r/w; 1 = output
  - 2 PIN: read-only, filtered input level; writes ignored
  - 3 RISE_EN: r/w
  - 4 FALL_EN: r/w
  - 5 STAT: read; write-1-to-clear
  - 6 OUT_SET: write ORs DataWr into OUT; reads 0
  - 7 OUT_CLR: write clears OUT bits where DataWr=1; reads 0
- Pin drive: P[i] = DIR[i] ? OUT[i] : Z. PIN reflects the pad level regardless of DIR, so outputs read back their own level.
- Input path: pad -> sync1 -> sync2 -> filt -> prev.
  - Rise[i] = filt & ~prev.
  - Fall[i] = ~filt & prev.
  - Latency from pad change to STAT set: 4 Clk edges without debounce.
- STAT[i] next state = (STAT[i] & ~clr[i]) | (Rise[i]&RISE_EN[i]) | (Fall[i]&FALL_EN[i]). A new event in the same cycle as its W1C: set wins.
- Enable gating: edges occurring while the enable is 0 are not recorded. Clearing an enable does not clear STAT.
- Irq register = |STAT, so Irq follows STAT by one cycle.
- Reset: OUT=0, DIR=0 (all inputs, pins Z), RISE_EN=FALL_EN=0, STAT=0, Irq=0, sync/filt/prev=0, debounce counter=0. Reset takes priority over a simultaneous write. No spurious STAT after reset, because the enables are 0.
- OUT_SET and OUT_CLR only modify OUT. Writes to OUT/DIR take effect on the pin the cycle after the write edge.

Optional Feature:
GPIO_DEBOUNCE_EN
- Defined:
  - A prescaler counts 0..DEB_DIV-1 and emits a tick at DEB_DIV-1.
  - On each tick, every pin shifts sync2 into a 2-bit history.
  - filt[i] updates to sync2 only when sync2 equals both history bits, i.e. 3 consecutive agreeing ticks.
  - Glitches shorter than 2*DEB_DIV cycles are rejected.
  - Edge latency is at most 3*DEB_DIV+4 cycles.
- Undefined: filt = sync2, with no prescaler or history logic generated.

Decomposition:
Shared package gpio_irq_pkg:
- register-select constants REG_OUT..REG_OUT_CLR (3-bit)
- BANK_BITS = 16
- MAX_WIDTH = 128

One sub-module, gpio_irq_bit, per pin (generate loop). It contains the synchronisers, optional debounce history, edge detect and STAT bit, with the tick and enables supplied from the parent. The parent holds bank registers, address decode, read mux and Irq.

Test Plan:
1. Reset then read all registers for all NBANK banks -> all 0; P fully Z; Irq=0. Read bank NBANK -> 0.
2. DIR bank0=0xFFFF, OUT bank0=0xA5A5 -> P[15:0]=0xA5A5. OUT_SET 0x000A -> OUT=0xA5AF. OUT_CLR 0x00F0 -> OUT=0xA50F. PIN bank0 reads 0xA50F.
3. DIR=0, RISE_EN bank1=0x0001, drive P[16] 0->1 -> STAT bank1=0x0001 four cycles later, Irq=1 one cycle after that. Write STAT 0x0001 -> STAT=0, Irq=0.
4. FALL_EN only on P[17]; toggle P[17] 1->0->1 -> only bit1 set. Repeat with RISE_EN=0 and FALL_EN=0 -> no STAT.
5. Issue a W1C of bit0 in the same cycle a new rising edge is detected on P[0] -> STAT bit0 stays 1.
6. GPIO_DEBOUNCE_EN, DEB_DIV=8: 10-cycle high pulse on P[0] -> PIN/STAT unchanged. 40-cycle high level -> PIN bit0=1 and STAT bit0 set within 28 cycles.
